// File: rtl/tick_cascade_if.sv
`default_nettype none
// ============================================================================
// Module   : tick_cascade_if
// Brief    : Control and tick bundle between a tick_cascade and its user.
// Revision : 1.0 - initial release
// ============================================================================
interface tick_cascade_if #(
  parameter int BASE_W     = 28,
  parameter int NUM_STAGES = 2,
  parameter int STAGE_W    = 8
);
  logic                          En;
  logic                          Clear;
  logic [BASE_W-1:0]             BaseDiv;
  logic [NUM_STAGES*STAGE_W-1:0] StageDiv;
  logic                          Tick;
  logic [NUM_STAGES-1:0]         StageTick;
  logic [BASE_W-1:0]             Phase;

  modport master (
    output En, Clear, BaseDiv, StageDiv,
    input  Tick, StageTick, Phase
  );

  modport slave (
    input  En, Clear, BaseDiv, StageDiv,
    output Tick, StageTick, Phase
  );
endinterface
`default_nettype wire

// File: rtl/tick_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tick_cascade
// Brief    : Base divider followed by cascaded stage dividers; emits 1-cycle
//            tick enables in the CLK domain.
// Revision : 1.0 - initial release
// ============================================================================
module tick_cascade #(
  parameter int BASE_W     = 28,
  parameter int NUM_STAGES = 2,
  parameter int STAGE_W    = 8
) (
  input  wire logic     CLK,
  input  wire logic     Reset,
  tick_cascade_if.slave tc
);

  localparam logic [BASE_W-1:0]  c_base_one  = BASE_W'(1);
  localparam logic [STAGE_W-1:0] c_stage_one = STAGE_W'(1);

  logic [BASE_W-1:0]     r_base_cnt;
  logic [BASE_W-1:0]     w_base_div_eff;
  logic                  w_adv;
  logic [NUM_STAGES-1:0] w_stage_ge;
  logic [NUM_STAGES:0]   w_wrap;
  logic                  r_tick;
  logic [NUM_STAGES-1:0] r_stage_tick;

  assign w_adv          = tc.En & ~tc.Clear;
  assign w_base_div_eff = (tc.BaseDiv <= c_base_one) ? c_base_one : tc.BaseDiv;

  // Wrap chain: a stage wraps only when its input wraps and it is at its limit.
  always_comb begin
    w_wrap    = '0;
    w_wrap[0] = w_adv & (r_base_cnt >= (w_base_div_eff - c_base_one));
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_wrap[k+1] = w_wrap[k] & w_stage_ge[k];
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_base_cnt <= '0;
    end else if (tc.Clear) begin
      r_base_cnt <= '0;
    end else if (tc.En) begin
      r_base_cnt <= w_wrap[0] ? '0 : r_base_cnt + c_base_one;
    end
  end

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      logic [STAGE_W-1:0] w_div;
      logic [STAGE_W-1:0] w_div_eff;
      logic [STAGE_W-1:0] r_cnt;

      assign w_div         = tc.StageDiv[k*STAGE_W +: STAGE_W];
      assign w_div_eff     = (w_div <= c_stage_one) ? c_stage_one : w_div;
      assign w_stage_ge[k] = (r_cnt >= (w_div_eff - c_stage_one));

      always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
          r_cnt <= '0;
        end else if (tc.Clear) begin
          r_cnt <= '0;
        end else if (w_wrap[k]) begin
          r_cnt <= w_wrap[k+1] ? '0 : r_cnt + c_stage_one;
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_tick       <= 1'b0;
      r_stage_tick <= '0;
    end else begin
      r_tick       <= w_wrap[0];
      r_stage_tick <= w_wrap[NUM_STAGES:1];
    end
  end

  assign tc.Tick      = r_tick;
  assign tc.StageTick = r_stage_tick;
  assign tc.Phase     = r_base_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tick_cascade.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_cascade
// Brief    : Directed self-checking bench for tick_cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tick_cascade;

  localparam int BASE_W     = 28;
  localparam int NUM_STAGES = 2;
  localparam int STAGE_W    = 8;

  logic CLK = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  tick_cascade_if #(.BASE_W(BASE_W), .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W)) tc ();

  tick_cascade #(.BASE_W(BASE_W), .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .tc    (tc)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // BaseDiv=4, StageDiv={3,2}: Tick every 4, StageTick[0] every 8, StageTick[1] every 24
  task automatic run_pattern(input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      step();
      chk("pat_phase", tc.Phase, n % 4);
      chk("pat_tick", tc.Tick, (n % 4) == 0);
      chk("pat_stick", tc.StageTick, {((n % 24) == 0), ((n % 8) == 0)});
    end
  endtask

  initial begin
    Reset       = 1'b0;
    tc.En       = 1'b0;
    tc.Clear    = 1'b0;
    tc.BaseDiv  = 28'd4;
    tc.StageDiv = {8'd3, 8'd2};
    step();
    step();
    chk("rst_tick", tc.Tick, 0);
    chk("rst_stick", tc.StageTick, 0);
    chk("rst_phase", tc.Phase, 0);

    // Test 1: nominal cascade
    #3;
    Reset = 1'b1;
    tc.En = 1'b1;
    run_pattern(48);

    // Test 2: degenerate divisors 0 and 1
    tc.Clear = 1'b1;
    step();
    chk("clr_phase", tc.Phase, 0);
    chk("clr_tick", tc.Tick, 0);
    tc.Clear    = 1'b0;
    tc.BaseDiv  = 28'd0;
    tc.StageDiv = {8'd1, 8'd0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("div0_tick", tc.Tick, 1);
      chk("div0_stick", tc.StageTick, 2'b11);
      chk("div0_phase", tc.Phase, 0);
    end
    tc.BaseDiv = 28'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("div1_tick", tc.Tick, 1);
      chk("div1_stick", tc.StageTick, 2'b11);
      chk("div1_phase", tc.Phase, 0);
    end

    // Test 3: En gap at Phase=5, BaseDiv=10
    tc.BaseDiv  = 28'd10;
    tc.StageDiv = {8'd3, 8'd2};
    tc.Clear    = 1'b1;
    step();
    tc.Clear = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("gap_pre_tick", tc.Tick, 0);
      chk("gap_pre_phase", tc.Phase, i);
    end
    tc.En = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("gap_tick", tc.Tick, 0);
      chk("gap_stick", tc.StageTick, 0);
      chk("gap_phase", tc.Phase, 5);
    end
    tc.En = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("gap_post_tick", tc.Tick, i == 5);
      chk("gap_post_phase", tc.Phase, (5 + i) % 10);
    end

    // Test 4: divisor shrinks below current count
    tc.BaseDiv = 28'd100;
    tc.Clear   = 1'b1;
    step();
    tc.Clear = 1'b0;
    repeat (60) step();
    chk("shrink_pre_phase", tc.Phase, 60);
    chk("shrink_pre_tick", tc.Tick, 0);
    tc.BaseDiv = 28'd20;
    step();
    chk("shrink_wrap_phase", tc.Phase, 0);
    chk("shrink_wrap_tick", tc.Tick, 1);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("shrink_tick", tc.Tick, i == 20);
      chk("shrink_phase", tc.Phase, i % 20);
    end

    // Test 5: Clear wins over En
    tc.BaseDiv = 28'd8;
    tc.Clear   = 1'b1;
    step();
    tc.Clear = 1'b0;
    repeat (3) step();
    chk("clr_pre_phase", tc.Phase, 3);
    tc.Clear = 1'b1;
    step();
    chk("clr_en_phase", tc.Phase, 0);
    chk("clr_en_tick", tc.Tick, 0);
    tc.Clear = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("clr_post_tick", tc.Tick, i == 8);
      chk("clr_post_phase", tc.Phase, i % 8);
    end

    // Test 6: async reset while pulses are high
    tc.BaseDiv  = 28'd4;
    tc.StageDiv = {8'd3, 8'd2};
    tc.Clear    = 1'b1;
    step();
    tc.Clear = 1'b0;
    repeat (6) step();
    chk("arst_pre_phase", tc.Phase, 2);
    repeat (2) step();
    chk("arst_pre_tick", tc.Tick, 1);
    chk("arst_pre_stick", tc.StageTick, 2'b01);
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_tick", tc.Tick, 0);
    chk("arst_stick", tc.StageTick, 0);
    chk("arst_phase", tc.Phase, 0);
    #1;
    Reset = 1'b1;
    run_pattern(24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
